cpu_result_uart: RTL and testbench

// - Downstream consumer of the CPU result port (out[WIDTH-1:0] / outFlag).
// - Captures one result word per rising edge of outFlag and queues it in a small FIFO.
// - Drains the FIFO over a UART 8N1 TX line, so results reach a host PC in byte order.
// - Runs on the 50 MHz board clock. outFlag comes from logic clocked by the divided clock,
//   so both inputs are resynchronised.

---
 rtl/cpu_result_uart.sv | 197 +++++++++++++++++++
 tb/tb_cpu_result_uart.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_result_uart.sv
// cpu_result_uart: resynchronises the CPU result port, queues result words in a FIFO and
// streams them least-significant byte first over UART (8N1, or 8E1 with CPU_UART_PARITY_EN).
module cpu_result_uart #(
  parameter int WIDTH        = 36,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outFlag,
  input  logic [WIDTH-1:0]       out,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int SW     = NBYTES * 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CPU_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic             f1_q, f2_q, f3_q;
  logic [WIDTH-1:0] d1_q, d2_q;
  logic             rise, full, push, pop;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  // Flag crosses from the divided-clock domain; data follows the same two-flop delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
      f3_q <= 1'b0;
    end else begin
      f1_q <= outFlag;
      f2_q <= f1_q;
      f3_q <= f2_q;
    end
  end

  always_ff @(posedge clock) begin
    d1_q <= out;
    d2_q <= d1_q;
  end

  assign rise = f2_q & ~f3_q;
  assign full = (count_q == FULL_CNT);
  assign push = rise & ~full;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= d2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (rise && full) overflow_q <= 1'b1;
    end
  end

  assign bit_end = (cnt_q == BIT_LAST);

  // tx_d is the line level for the state being entered, so tx comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = '0;
          byte_d  = '0;
          shift_d = SW'(mem_q[rd_ptr_q]);
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef CPU_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shift_q[7:0];
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[bit_d];
          end
        end
      end
`ifdef CPU_UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == BYTE_LAST) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 1'b1;
            shift_d = shift_q >> 8;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_cpu_result_uart.sv
// Bench for cpu_result_uart: queue-based reference model plus a UART receiver that
// decodes tx back into words; directed vectors followed by randomized flag pulses.
`timescale 1ns/1ps
module tb_cpu_result_uart;
  localparam int WIDTH  = 36;
  localparam int DEPTH  = 4;
  localparam int CPB    = 4;
  localparam int NBYTES = 5;
`ifdef CPU_UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME = NBYTES * BITS * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flag = 1'b0;
  logic [WIDTH-1:0] word = '0;
  logic             tx, busy, ovf;
  logic [2:0]       cnt;

  cpu_result_uart #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock(clk), .reset(rst), .outFlag(flag), .out(word),
    .tx(tx), .busy(busy), .overflow(ovf), .fifo_count(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] expq[$];
  int               m_rem = 0;
  bit               m_ovf = 0;
  bit               h1 = 0, h2 = 0, h3 = 0;
  logic [WIDTH-1:0] o1 = '0, o2 = '0;
  int               cyc = 0;
  int               max_cnt = 0;
  int               fall_cyc = -1;
  bit               prev_busy = 0;

  // receiver state
  bit               rx_act = 0;
  int               rx_idx = 0;
  logic [BITS-1:0]  rx_bits;
  logic [7:0]       rx_bytes[$];
  logic [7:0]       last_b [NBYTES];
  int               rx_words = 0;

  typedef struct {
    logic [WIDTH-1:0] w;
    logic [7:0] b0, b1, b2, b3, b4;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete(); expq.delete(); rx_bytes.delete();
    m_rem = 0; m_ovf = 0; h1 = 0; h2 = 0; h3 = 0;
    rx_act = 0; rx_idx = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at that edge.
  task automatic model_edge(input bit f, input logic [WIDTH-1:0] w);
    bit rise, pop, pushok;
    rise   = h2 & ~h3;
    pop    = (m_rem == 0) && (mq.size() > 0);
    pushok = rise && (mq.size() < DEPTH);
    if (rise && !pushok) m_ovf = 1;
    if (m_rem > 0) m_rem--;
    if (pop) begin
      expq.push_back(mq.pop_front());
      m_rem = FRAME;
    end
    if (pushok) mq.push_back(o2);
    h3 = h2; h2 = h1; h1 = f;
    o2 = o1; o1 = w;
  endtask

  task automatic rx_edge();
    int b;
    logic [39:0] w40;
    if (!rx_act) begin
      if (tx == 1'b0) begin
        rx_act = 1;
        rx_idx = 0;
      end
    end else begin
      rx_idx++;
    end
    if (rx_act && (rx_idx % CPB) == CPB / 2) begin
      b = rx_idx / CPB;
      rx_bits[b] = tx;
      if (b == BITS - 1) begin
        rx_act = 0;
        chk("rx_start_bit", rx_bits[0], 1'b0);
        chk("rx_stop_bit", rx_bits[BITS-1], 1'b1);
`ifdef CPU_UART_PARITY_EN
        chk("rx_parity_bit", rx_bits[9], ^rx_bits[8:1]);
`endif
        rx_bytes.push_back(rx_bits[8:1]);
        if (rx_bytes.size() == NBYTES) begin
          for (int i = 0; i < NBYTES; i++) last_b[i] = rx_bytes[i];
          w40 = {rx_bytes[4], rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
          rx_bytes.delete();
          rx_words++;
          chk("rx_word_was_expected", expq.size() > 0, 1'b1);
          if (expq.size() > 0) chk("rx_word", w40, {4'b0, expq.pop_front()});
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_overflow", ovf, 1'b0);
      chk("reset_count", cnt, 0);
    end else begin
      model_edge(flag, word);
      rx_edge();
      chk("fifo_count", cnt, mq.size());
      chk("busy", busy, (m_rem > 0) || (mq.size() > 0));
      chk("overflow", ovf, m_ovf);
      if (m_rem == 0) chk("tx_idle_high", tx, 1'b1);
    end
    if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [WIDTH-1:0] w, input int hi, input int lo);
    word = w;
    flag = 1'b1;
    repeat (hi) step();
    flag = 1'b0;
    repeat (lo) step();
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || m_rem > 0 || mq.size() > 0 || rx_act) && n < maxc) begin
      step();
      n++;
    end
    chk("wait_idle_within_bound", n < maxc, 1'b1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, c0, push_cyc;
    logic [63:0] r64;

    tbl[0] = '{36'hA_1234_5678, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A};
    tbl[1] = '{36'hF_FFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    tbl[2] = '{36'h0_0000_0007, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{36'h5_A5C3_3C81, 8'h81, 8'h3C, 8'hC3, 8'hA5, 8'h05};

    do_reset(3);

    // Single words held high for 20 clocks: one push, fixed latency, exact byte order.
    for (int i = 0; i < 4; i++) begin
      do_reset(2);
      w0 = rx_words;
      fall_cyc = -1;
      word = tbl[i].w;
      flag = 1'b1;
      step(); step();
      chk("push_not_before_clock3", cnt, 0);
      step();
      chk("push_on_clock3", cnt, 1);
      push_cyc = cyc;
      repeat (17) step();
      flag = 1'b0;
      wait_idle(FRAME + 50);
      chk("one_word_for_held_flag", rx_words - w0, 1);
      chk("busy_drop_after_push", fall_cyc - push_cyc, FRAME + 1);
      chk("byte0", last_b[0], tbl[i].b0);
      chk("byte1", last_b[1], tbl[i].b1);
      chk("byte2", last_b[2], tbl[i].b2);
      chk("byte3", last_b[3], tbl[i].b3);
      chk("byte4", last_b[4], tbl[i].b4);
    end

    // Overflow: six pulses while the first word is still shifting.
    do_reset(2);
    w0 = rx_words;
    max_cnt = 0;
    for (int i = 1; i <= 6; i++) pulse(WIDTH'(i), 3, 3);
    chk("overflow_max_count", max_cnt, DEPTH);
    chk("overflow_flag_set", ovf, 1'b1);
    wait_idle(6 * (FRAME + 1) + 50);
    chk("overflow_words_sent", rx_words - w0, 5);
    chk("overflow_sticky", ovf, 1'b1);

    // Push lands on the same edge as the IDLE pop of the second word.
    do_reset(2);
    w0 = rx_words;
    c0 = cyc;
    pulse(36'h1_1111_1111, 3, 3);
    pulse(36'h2_2222_2222, 3, 0);
    while (cyc < c0 + FRAME + 2) step();
    word = 36'h3_3333_3333;
    flag = 1'b1;
    repeat (3) step();
    chk("simul_push_pop_count", cnt, 1);
    flag = 1'b0;
    wait_idle(3 * (FRAME + 1) + 50);
    chk("simul_words_sent", rx_words - w0, 3);

    // Reset during DATA bit 3 of byte 2 (byte2 = 8'h12, bit3 = 0).
    do_reset(2);
    c0 = cyc;
    pulse(36'h3_0012_3456, 3, 3);
    pulse(36'h4_4444_4444, 3, 0);
    while (cyc < c0 + 4 + 2 * BITS * CPB + 4 * CPB + 1) step();
    chk("pre_reset_tx_data_bit", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    chk("async_reset_count", cnt, 0);
    chk("async_reset_busy", busy, 1'b0);
    do_reset(2);
    w0 = rx_words;
    repeat (300) step();
    chk("no_frames_after_reset", rx_words - w0, 0);

    // Nine sequential words wrap the pointers twice.
    do_reset(2);
    w0 = rx_words;
    for (int i = 0; i < 9; i++) begin
      r64 = {$urandom, $urandom};
      pulse(r64[WIDTH-1:0], 3, 3);
      wait_idle(FRAME + 50);
    end
    chk("wrap_words_sent", rx_words - w0, 9);

    // Random pulse trains, including bursts that overflow.
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      r64 = {$urandom, $urandom};
      pulse(r64[WIDTH-1:0], $urandom_range(1, 8), $urandom_range(2, 80));
    end
    wait_idle(DEPTH * (FRAME + 1) + FRAME + 100);
    chk("all_words_delivered", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
